// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM access arbiter.
// The arbitration mode is chosen by SRAM_ARB_ROUND_ROBIN_EN in sram_access_arbiter.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_t;

  localparam int PORT_CPU = 0;
  localparam int PORT_DBG = 1;

  localparam int WAIT_MIN = 1;
  localparam int WAIT_MAX = 15;

  // Out-of-range wait counts are pinned to the nearest legal value.
  function automatic int wait_clamp(input int w);
    if (w < WAIT_MIN) return WAIT_MIN;
    if (w > WAIT_MAX) return WAIT_MAX;
    return w;
  endfunction

endpackage

// File: rtl/sram_arb_pick.sv
// Combinational winner select between the CPU and debug requesters.
// On a tie, rr_mode=1 favours the port that was not served last; rr_mode=0 favours port 0.
module sram_arb_pick (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       rr_mode,
  output logic       valid,
  output logic       winner
);

  always_comb begin
    valid  = |req;
    winner = 1'b0;
    case (req)
      2'b10:   winner = 1'b1;
      2'b11:   winner = rr_mode ? ~last : 1'b0;
      default: winner = 1'b0;
    endcase
  end

endmodule

// File: rtl/sram_access_arbiter.sv
// Two-port SRAM access sequencer: arbitrates, latches the request, holds OE/WE for WAIT_CYCLES.
// Define SRAM_ARB_ROUND_ROBIN_EN for round-robin tie-break; otherwise port 0 has fixed priority.
module sram_access_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W      = 20,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic [1:0]        req,
  input  logic [1:0]        we,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic [1:0]        gnt,
  output logic [1:0]        done,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] Mem_ADDR,
  output logic              Mem_OE,
  output logic              Mem_WE,
  output logic [DATA_W-1:0] Mem_DOUT,
  output logic              Mem_DRIVE,
  input  logic [DATA_W-1:0] Mem_DIN,
  output arb_state_t        dbg_state
);

  localparam int WAIT_EFF = wait_clamp(WAIT_CYCLES);
  localparam int CNT_W    = $clog2(WAIT_EFF + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_EFF - 1);

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  localparam logic RR_MODE = 1'b1;
`else
  localparam logic RR_MODE = 1'b0;
`endif

  arb_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              we_q;
  logic              win_q;
  logic              last_q;
  logic              pick_valid;
  logic              pick_winner;
  logic              access_last;

  sram_arb_pick u_pick (
    .req     (req),
    .last    (last_q),
    .rr_mode (RR_MODE),
    .valid   (pick_valid),
    .winner  (pick_winner)
  );

  assign access_last = (state_q == ACCESS) && (cnt_q == '0);
  assign dbg_state   = state_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      win_q   <= 1'b0;
      last_q  <= 1'b1;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && pick_valid) begin
        win_q <= pick_winner;
        cnt_q <= CNT_INIT;
        if (pick_winner) begin
          addr_q  <= addr1;
          wdata_q <= wdata1;
          we_q    <= we[1];
        end else begin
          addr_q  <= addr0;
          wdata_q <= wdata0;
          we_q    <= we[0];
        end
      end else if (state_q == ACCESS && cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
      end
      // Read data is sampled at the end of the last OE cycle.
      if (access_last && !we_q) begin
        if (win_q) rdata1 <= Mem_DIN;
        else       rdata0 <= Mem_DIN;
      end
      if (state_q == DONE) last_q <= win_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt       = '0;
    done      = '0;
    Mem_ADDR  = '0;
    Mem_OE    = 1'b0;
    Mem_WE    = 1'b0;
    Mem_DRIVE = 1'b0;
    Mem_DOUT  = '0;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          gnt[PORT_CPU] = ~pick_winner;
          gnt[PORT_DBG] = pick_winner;
          state_d       = ACCESS;
        end
      end
      ACCESS: begin
        Mem_ADDR  = addr_q;
        Mem_OE    = ~we_q;
        Mem_WE    = we_q;
        Mem_DRIVE = we_q;
        if (we_q) Mem_DOUT = wdata_q;
        if (cnt_q == '0) state_d = DONE;
      end
      DONE: begin
        // Bus turnaround: all strobes low while done pulses.
        done[PORT_CPU] = ~win_q;
        done[PORT_DBG] = win_q;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
